// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, header nibble, bit clock divider.
// UART_ARB_ID_PREFIX_EN adds the header-frame states.
package uart_pkg;

    typedef enum logic [2:0] {
        ARB,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
`ifdef UART_ARB_ID_PREFIX_EN
        ,
        HDR_ISSUE,
        HDR_WAIT_BUSY,
        HDR_WAIT_DONE
`endif
    } state_t;

    localparam logic [3:0] UART_HDR_NIBBLE = 4'hA;

    // Clock cycles per serial bit, shared with the uart_tx instance.
    localparam int CLOCK_DIV = 4;

    function automatic logic [7:0] hdr_byte(input logic [2:0] id);
        return {UART_HDR_NIBBLE, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // NOTE: every variable gets a default before the loop, so no path leaves one unassigned (no latch).
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        // Walk offsets from farthest to nearest so the nearest hit is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers with round-robin grants.
// Define UART_ARB_ID_PREFIX_EN to precede each byte with a {4'hA, 0, id} header frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 uart_start,
    output logic [7:0]           uart_data,
    input  logic                 uart_busy,
    output logic                 active,
    output logic [ID_W-1:0]      cur_id,
    output logic                 err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               start_d, active_d, err_d;
    logic [7:0]         data_d;
    logic [ID_W-1:0]    id_d;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [7:0]         grant_byte;
    logic               timed_out;

`ifdef UART_ARB_ID_PREFIX_EN
    logic [7:0] payload_q, payload_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req         (req),
        .rr_ptr      (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant_byte = req_data[8*grant_id +: 8];
    assign timed_out  = (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        start_d  = 1'b0;
        err_d    = 1'b0;
        data_d   = uart_data;
        active_d = active;
        id_d     = cur_id;
`ifdef UART_ARB_ID_PREFIX_EN
        payload_d = payload_q;
`endif
        unique case (state_q)
            ARB: begin
                if (grant_valid) begin
                    id_d     = grant_id;
                    ack_d    = NUM_REQ'(1) << grant_id;
                    active_d = 1'b1;
                    ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
`ifdef UART_ARB_ID_PREFIX_EN
                    data_d    = hdr_byte(3'(grant_id));
                    payload_d = grant_byte;
                    state_d   = HDR_ISSUE;
`else
                    data_d  = grant_byte;
                    state_d = ISSUE;
`endif
                end else begin
                    active_d = 1'b0;
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    active_d = 1'b0;
                    state_d  = ARB;
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            HDR_ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = HDR_WAIT_BUSY;
            end
            HDR_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = HDR_WAIT_DONE;
                end else if (timed_out) begin
                    // Abandoning the header drops the payload as well.
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HDR_WAIT_DONE: begin
                if (!uart_busy) begin
                    data_d  = payload_q;
                    state_d = ISSUE;
                end
            end
`endif
            default: state_d = ARB;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ack        <= '0;
            uart_start <= 1'b0;
            uart_data  <= 8'h00;
            active     <= 1'b0;
            cur_id     <= '0;
            err        <= 1'b0;
`ifdef UART_ARB_ID_PREFIX_EN
            payload_q  <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ack        <= ack_d;
            uart_start <= start_d;
            uart_data  <= data_d;
            active     <= active_d;
            cur_id     <= id_d;
            err        <= err_d;
`ifdef UART_ARB_ID_PREFIX_EN
            payload_q  <= payload_d;
`endif
        end
    end

endmodule
